snake_game_ctrl: RTL
====================

Name: snake_game_ctrl

Overview:
Game-flow controller for the snake game: sequences start, run, pause, death and game-over phases. It gates and rescales the base game tick into the move tick consumed by the snake core. It also drives a soft reset to the core/apple/collision datapath, owns the BCD score, and raises the speed level as apples are eaten. It sits between game_tick/input_controller_adv and snake_core_grow; the renderer consumes state, score and blink.

Parameters:
BASE_DIV, 4, tick_in pulses per move at level 0
MIN_DIV, 1, fastest divider; level saturates when BASE_DIV-level reaches it
LEVEL_STEP, 5, apples eaten per level increase
DEATH_FRAMES, 60, frames spent in DYING before OVER
SOFT_RST_CYC, 4, clk_pix cycles core_rst_n is held low in CLEAR

Ports:
clk_pix  in  1  pixel clock, only clock
reset_n  in  1  asynchronous active-low reset
tick_in  in  1  base game tick, 1-cycle pulse
frame_start  in  1  1-cycle pulse at pixel (0,0)
btn_start_n  in  1  synchronised and debounced start button, active-low level
btn_pause_n  in  1  synchronised and debounced pause button, active-low level
eat_evt  in  1  apple eaten, 1-cycle pulse
self_hit  in  1  snake core self-collision flag
tick_run  out  1  move pulse to snake core
core_rst_n  out  1  active-low soft reset to the datapath
state  out  3  current FSM state
score_tens  out  4  BCD score tens digit
score_ones  out  4  BCD score ones digit
level  out  3  current speed level
blink  out  1  death-flash enable for the renderer

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all counters, score and level = 0.
  - tick_run=0, blink=0.
  - core_rst_n=0 immediately, without waiting for a clock edge.
- Button press = registered falling edge of the *_n input, giving 1 press pulse per push. A held level never repeats.
- State encoding: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DYING=4, OVER=5.
- IDLE: core_rst_n=0, tick_run=0. Start press -> CLEAR.
- CLEAR:
  - core_rst_n=0 for exactly SOFT_RST_CYC cycles.
  - Clears score, level, eat counter and divider counter.
  - Then -> RUN; core_rst_n=1 from the first RUN cycle.
- RUN:
  - Divider counter increments on each tick_in.
  - When the counter equals cur_div-1 on a tick_in, the counter wraps to 0 and tick_run pulses in the next cycle (latency 1, registered).
  - cur_div = max(BASE_DIV-level, MIN_DIV).
- RUN, on eat_evt:
  - BCD score increments; 99 wraps to 00.
  - Eat counter increments; on reaching LEVEL_STEP it clears and level increments.
  - Level saturates once cur_div==MIN_DIV and never wraps.
- RUN, pause press -> PAUSE. The divider counter is retained; tick_in is ignored while paused.
- RUN, self_hit=1 in any cycle -> DYING.
  - tick_run is forced 0 from the next cycle.
  - A tick_run already registered may still appear in the cycle of the transition.
- PAUSE:
  - Pause press -> RUN with the divider continuing from its retained value.
  - Start press is ignored; eat_evt and self_hit are ignored.
- DYING:
  - Counts frame_start pulses.
  - blink toggles every 8 frames, starting at 1 on entry.
  - After DEATH_FRAMES frames -> OVER.
  - Button presses are ignored.
- OVER: blink=0, score held for display. Start press -> CLEAR.
- eat_evt outside RUN: ignored.
- Simultaneous events:
  - eat_evt with self_hit: the score still increments, then -> DYING.
  - pause press with self_hit: DYING wins.
  - start and pause press together in RUN: pause wins.
- Widths: divider counter $clog2(BASE_DIV+1) bits; eat counter $clog2(LEVEL_STEP+1) bits; frame counter 7 bits.

Decomposition:
- Package snake_pkg: state encoding localparams, and the BCD digit width.
- One sub-module, bcd_score_counter: 2-digit BCD with clear and increment inputs, 99->00 wrap, asynchronous active-low reset.
- The FSM, divider, level logic and button edge detection stay in snake_game_ctrl.

Test Plan:
- Reset release, then start pressed -> state 0->1.
  - core_rst_n low for exactly 4 cycles, then state=2 and core_rst_n=1.
- RUN at level 0, 12 tick_in pulses -> exactly 3 tick_run pulses, each 1 cycle after the 4th, 8th and 12th tick_in.
- 5 eat_evt pulses -> score 05 and level 1; cur_div=3.
  - Continue eating; level stops at 3 (div=1) and tick_run then follows every tick_in.
- 99 eat_evt pulses, then 1 more -> score 99 then 00; level saturated at 3.
- Pause press after 2 of 4 tick_in -> state=3; 10 tick_in pulses produce no tick_run.
  - Pause press again -> first tick_run appears after 2 more tick_in.
- self_hit and eat_evt in the same cycle -> score +1, state=4, tick_run=0 thereafter, blink toggles every 8 frames.
  - After 60 frame_start pulses -> state=5.
  - Start press -> CLEAR, score 00.
- Also: reset_n asserted mid-RUN -> core_rst_n=0 and state=0 asynchronously, with no clock edge required.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game flow controller.
//   state_t : game-flow FSM state encoding, also exported on the state port
//   BCD_W   : width of one BCD score digit
package snake_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DYING = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

endpackage

// File: rtl/snake_game_ctrl_bcd_score_counter.sv
// Two-digit BCD score counter, wraps 99 -> 00.
//   clk_pix, reset_n : clock and asynchronous active-low reset
//   clr              : synchronous clear to 00 (has priority over inc)
//   inc              : add one to the score
//   tens, ones       : BCD digits
module bcd_score_counter
  import snake_pkg::*;
(
  input  logic             clk_pix,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (ones_q == BCD_W'(9)) begin
        ones_d = '0;
        tens_d = (tens_q == BCD_W'(9)) ? '0 : tens_q + BCD_W'(1);
      end else begin
        ones_d = ones_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the snake game.
// Sequences IDLE/CLEAR/RUN/PAUSE/DYING/OVER, turns the base tick into the
// snake move tick (slowed by a level-dependent divider), holds the datapath
// in soft reset outside play, keeps the BCD score and the speed level, and
// produces the death-flash blink.
//   clk_pix, reset_n         : clock, asynchronous active-low reset
//   tick_in, frame_start     : base game tick and frame start pulses
//   btn_start_n, btn_pause_n : debounced active-low buttons (level)
//   eat_evt, self_hit        : apple eaten pulse, self-collision flag
//   tick_run, core_rst_n     : move pulse and soft reset to the datapath
//   state, score_tens/ones   : FSM state and BCD score for the renderer
//   level, blink             : speed level and death-flash enable
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int BASE_DIV     = 4,
  parameter int MIN_DIV      = 1,
  parameter int LEVEL_STEP   = 5,
  parameter int DEATH_FRAMES = 60,
  parameter int SOFT_RST_CYC = 4
) (
  input  logic             clk_pix,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             frame_start,
  input  logic             btn_start_n,
  input  logic             btn_pause_n,
  input  logic             eat_evt,
  input  logic             self_hit,
  output logic             tick_run,
  output logic             core_rst_n,
  output logic [2:0]       state,
  output logic [BCD_W-1:0] score_tens,
  output logic [BCD_W-1:0] score_ones,
  output logic [2:0]       level,
  output logic             blink
);

  localparam int DIV_W = $clog2(BASE_DIV + 1);
  localparam int EAT_W = $clog2(LEVEL_STEP + 1);
  localparam int CLR_W = $clog2(SOFT_RST_CYC + 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [EAT_W-1:0] eat_cnt_q, eat_cnt_d;
  logic [2:0]       level_q, level_d;
  logic [6:0]       frame_cnt_q, frame_cnt_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             tick_run_q, tick_run_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             blink_q, blink_d;
  logic             start_prev_q, pause_prev_q;

  logic             start_press, pause_press;
  logic [DIV_W-1:0] cur_div;
  logic             at_min;
  logic             score_clr, score_inc;

  // Press = previous sample released, current sample pressed; a held
  // button therefore yields a single pulse.
  assign start_press = start_prev_q & ~btn_start_n;
  assign pause_press = pause_prev_q & ~btn_pause_n;

  // cur_div = max(BASE_DIV - level, MIN_DIV)
  always_comb begin
    if (int'(level_q) >= BASE_DIV - MIN_DIV) cur_div = DIV_W'(MIN_DIV);
    else                                     cur_div = DIV_W'(BASE_DIV - int'(level_q));
  end
  assign at_min = (cur_div == DIV_W'(MIN_DIV));

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    eat_cnt_d   = eat_cnt_q;
    level_d     = level_q;
    frame_cnt_d = '0;
    clr_cnt_d   = '0;
    tick_run_d  = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_press) state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        score_clr = 1'b1;
        div_cnt_d = '0;
        eat_cnt_d = '0;
        level_d   = '0;
        clr_cnt_d = clr_cnt_q + CLR_W'(1);
        if (clr_cnt_q == CLR_W'(SOFT_RST_CYC - 1)) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (tick_in) begin
          // >= rather than == so a level-up that shrinks the divider below
          // the current count still wraps on the next tick.
          if (div_cnt_q >= cur_div - DIV_W'(1)) begin
            div_cnt_d  = '0;
            tick_run_d = ~self_hit;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        if (eat_evt) begin
          score_inc = 1'b1;
          if (eat_cnt_q == EAT_W'(LEVEL_STEP - 1)) begin
            eat_cnt_d = '0;
            if (!at_min) level_d = level_q + 3'd1;
          end else begin
            eat_cnt_d = eat_cnt_q + EAT_W'(1);
          end
        end
        if (self_hit)         state_d = ST_DYING;
        else if (pause_press) state_d = ST_PAUSE;
      end

      ST_PAUSE: begin
        if (pause_press) state_d = ST_RUN;
      end

      ST_DYING: begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
          if (frame_cnt_q == 7'(DEATH_FRAMES - 1)) begin
            frame_cnt_d = '0;
            state_d     = ST_OVER;
          end else begin
            frame_cnt_d = frame_cnt_q + 7'd1;
          end
        end
      end

      ST_OVER: begin
        if (start_press) state_d = ST_CLEAR;
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame count is 0 on entry, so blink starts at 1 and flips every 8 frames.
    blink_d      = (state_d == ST_DYING) && !frame_cnt_d[3];
    core_rst_n_d = (state_d != ST_IDLE) && (state_d != ST_CLEAR);
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      eat_cnt_q    <= '0;
      level_q      <= '0;
      frame_cnt_q  <= '0;
      clr_cnt_q    <= '0;
      tick_run_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      blink_q      <= 1'b0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      eat_cnt_q    <= eat_cnt_d;
      level_q      <= level_d;
      frame_cnt_q  <= frame_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      tick_run_q   <= tick_run_d;
      core_rst_n_q <= core_rst_n_d;
      blink_q      <= blink_d;
      start_prev_q <= btn_start_n;
      pause_prev_q <= btn_pause_n;
    end
  end

  bcd_score_counter u_score (
    .clk_pix (clk_pix),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .tens    (score_tens),
    .ones    (score_ones)
  );

  assign state      = state_q;
  assign tick_run   = tick_run_q;
  assign core_rst_n = core_rst_n_q;
  assign level      = level_q;
  assign blink      = blink_q;

endmodule
